spike_rate_decoder: RTL and testbench
=====================================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter WINDOW_LEN, default 16: number of sample cycles per counting window; legal range 2..256.
REQ-002 SHALL have parameter NUM_CH, fixed at 4: number of spike channels decoded.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: starts and sustains windowed counting.
REQ-006 SHALL have port spike_in, input, 4 bits: one spike flag per channel, one spike per cycle per channel maximum.
REQ-007 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-008 SHALL have port rate_out, output, 16 bits: channel i count at bits [4i+3:4i].
REQ-009 SHALL have port rate_valid, output, 1 bit: rate_out holds an unaccepted result.
REQ-010 SHALL have port sat, output, 4 bits: per-channel saturation flags for the result in rate_out.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag, a completed window was discarded.
REQ-012 SHALL have port busy, output, 1 bit: high while the state is COUNT.

Function
REQ-013 SHALL implement two states: IDLE and COUNT.
REQ-014 SHALL leave IDLE for COUNT on the cycle after en is sampled high; the window counter and all channel counters are 0 on entry.
REQ-015 SHALL, in each COUNT cycle, sample spike_in: spike_in[i]=1 increments channel i's counter by 1, saturating at 15.
REQ-016 SHALL set that channel's window-saturation bit when a spike arrives at count 15; the bit is cleared at window start.
REQ-017 SHALL complete a window after exactly WINDOW_LEN COUNT samples, i.e. when the window counter reaches WINDOW_LEN-1 and that cycle's spikes are included.
REQ-018 SHALL, at window completion, restart counting the next cycle with counters cleared while en=1 (back-to-back windows, no gap cycle), and return to IDLE if en=0.
REQ-019 SHALL drop en=0 during COUNT before completion: the partial window is discarded, counters are cleared, the state returns to IDLE next cycle, and no result or overrun is produced.
REQ-020 SHALL, at window completion with rate_valid=0, load rate_out and sat from the final counts and assert rate_valid the next cycle (1-cycle latency after the last sample).
REQ-021 SHALL treat rate_valid & out_ready in one cycle as a transfer: rate_valid deasserts the next cycle unless REQ-022 applies.
REQ-022 SHALL, when a transfer and a window completion coincide, load the new result and keep rate_valid high with no bubble.
REQ-023 SHALL, when a window completes with rate_valid=1 and no transfer that cycle, discard the new result, keep rate_out/sat unchanged, and set overrun.
REQ-024 SHALL hold rate_out and sat stable while rate_valid=1 and out_ready=0.
REQ-025 SHALL clear overrun only by reset.
REQ-026 SHALL keep a pending result valid when en falls; it is still delivered via the handshake.
REQ-027 SHALL size the window counter as ceil(log2(WINDOW_LEN)) bits with no wrap ambiguity at WINDOW_LEN=256.

Reset
REQ-028 SHALL, while rst_n=0 at a clock edge, set state=IDLE, all counters=0, rate_out=16'h0000, sat=4'h0, rate_valid=0, overrun=0, busy=0, regardless of the current state or a pending result.
REQ-029 SHALL begin operation on the first edge with rst_n=1 and en sampled.

Verification (WINDOW_LEN=16)
REQ-030 SHALL check reset: rst_n=0 for 2 cycles mid-window with rate_valid=1 -> all outputs 0 on the following cycle.
REQ-031 SHALL check decoding: en=1, over one window ch0 spikes every cycle, ch1 every other cycle, ch2 never, ch3 once; out_ready=1 -> one cycle after the 16th sample rate_out=16'h108F, sat=4'b0001, rate_valid=1 for 1 cycle.
REQ-032 SHALL check backpressure: out_ready=0 across two full windows -> first result held, second window discarded, overrun=1; out_ready=1 then transfers the first result.
REQ-033 SHALL check a coincident event: out_ready rises on the same cycle the next window completes -> rate_valid stays 1 and rate_out updates to the new result with no gap.
REQ-034 SHALL check an abort: en=0 after 7 COUNT samples -> IDLE next cycle, busy=0, no rate_valid, overrun unchanged; en=1 again -> fresh 16-sample window.
REQ-035 SHALL check minimum window: WINDOW_LEN=2 with constant spikes on all channels -> rate_out=16'h2222 every 2 cycles with out_ready=1.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: counts spikes per channel over fixed windows, delivers saturated counts via valid/ready
module spike_rate_decoder #(
    parameter int WINDOW_LEN = 16,
    parameter int NUM_CH     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NUM_CH-1:0]     spike_in,
    input  logic                  out_ready,
    output logic [4*NUM_CH-1:0]   rate_out,
    output logic                  rate_valid,
    output logic [NUM_CH-1:0]     sat,
    output logic                  overrun,
    output logic                  busy
);
    localparam int CW = $clog2(WINDOW_LEN);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            win_q, win_d;
    logic [NUM_CH-1:0][3:0]   cnt_q, cnt_d, cnt_n;
    logic [NUM_CH-1:0]        wsat_q, wsat_d, wsat_n;
    logic [4*NUM_CH-1:0]      rate_q, rate_d;
    logic [NUM_CH-1:0]        sat_q, sat_d;
    logic                     valid_q, valid_d;
    logic                     overrun_q, overrun_d;
    logic                     done, xfer;

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        wsat_d    = wsat_q;
        rate_d    = rate_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        done      = 1'b0;
        xfer      = valid_q & out_ready;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_n[i]  = cnt_q[i] + 4'(spike_in[i] & ~&cnt_q[i]);
            wsat_n[i] = wsat_q[i] | (spike_in[i] & &cnt_q[i]);
        end
        if (state_q == IDLE) begin
            state_d = en ? COUNT : IDLE;
        end else begin
            done   = win_q == CW'(WINDOW_LEN - 1);
            win_d  = win_q + CW'(1);
            cnt_d  = cnt_n;
            wsat_d = wsat_n;
            // completion or abort both start the next window from zero
            if (done || !en) begin
                state_d = en ? COUNT : IDLE;
                win_d   = '0;
                cnt_d   = '0;
                wsat_d  = '0;
            end
        end
        if (xfer)
            valid_d = 1'b0;
        if (done && (!valid_q || xfer)) begin
            rate_d  = cnt_n;
            sat_d   = wsat_n;
            valid_d = 1'b1;
        end else if (done) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= '0;
            cnt_q     <= '0;
            wsat_q    <= '0;
            rate_q    <= '0;
            sat_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            wsat_q    <= wsat_d;
            rate_q    <= rate_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rate_out   = rate_q;
    assign sat        = sat_q;
    assign rate_valid = valid_q;
    assign overrun    = overrun_q;
    assign busy       = state_q == COUNT;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed bench with a window-sum reference model for WINDOW_LEN 16 and 2
module tb_spike_rate_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  spk = 4'h0;
    logic        rdy = 1'b0;
    logic [15:0] rate_a, rate_b;
    logic        valid_a, valid_b, ovr_a, ovr_b, busy_a, busy_b;
    logic [3:0]  sat_a, sat_b;

    int n_chk = 0;
    int n_fail = 0;

    int          wl [2] = '{16, 2};
    int          n_s [2];
    int          sum [2][4];
    bit          on [2];
    bit          v [2];
    bit          ov [2];
    logic [15:0] r [2];
    logic [3:0]  s [2];

    spike_rate_decoder #(.WINDOW_LEN(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spk), .out_ready(rdy),
        .rate_out(rate_a), .rate_valid(valid_a), .sat(sat_a), .overrun(ovr_a), .busy(busy_a)
    );
    spike_rate_decoder #(.WINDOW_LEN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .spike_in(spk), .out_ready(rdy),
        .rate_out(rate_b), .rate_valid(valid_b), .sat(sat_b), .overrun(ovr_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // a window's result is just the clamped sum of its spikes; sat means the sum exceeded 15
    task automatic model_step(input int k);
        bit xf, dn;
        logic [15:0] rr;
        logic [3:0] ss;
        if (!rst_n) begin
            on[k] = 0; n_s[k] = 0; v[k] = 0; ov[k] = 0; r[k] = '0; s[k] = '0;
            for (int c = 0; c < 4; c++) sum[k][c] = 0;
            return;
        end
        xf = v[k] && rdy;
        dn = 0;
        rr = '0;
        ss = '0;
        if (!on[k]) begin
            on[k] = en;
        end else begin
            n_s[k]++;
            for (int c = 0; c < 4; c++) sum[k][c] += int'(spk[c]);
            if (n_s[k] == wl[k]) begin
                dn = 1;
                for (int c = 0; c < 4; c++) begin
                    rr[4*c +: 4] = sum[k][c] > 15 ? 4'hF : 4'(sum[k][c]);
                    ss[c] = sum[k][c] > 15;
                end
            end
            if (dn || !en) begin
                n_s[k] = 0;
                for (int c = 0; c < 4; c++) sum[k][c] = 0;
                on[k] = en;
            end
        end
        if (dn) begin
            if (!v[k] || xf) begin
                r[k] = rr; s[k] = ss; v[k] = 1;
            end else begin
                ov[k] = 1;
            end
        end else if (xf) begin
            v[k] = 0;
        end
    endtask

    task automatic tick(input logic e, input logic [3:0] sp, input logic rd);
        en = e; spk = sp; rdy = rd;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("a_rate", 32'(rate_a), 32'(r[0]));
        chk("a_sat", 32'(sat_a), 32'(s[0]));
        chk("a_valid", 32'(valid_a), 32'(v[0]));
        chk("a_overrun", 32'(ovr_a), 32'(ov[0]));
        chk("a_busy", 32'(busy_a), 32'(on[0]));
        chk("b_rate", 32'(rate_b), 32'(r[1]));
        chk("b_sat", 32'(sat_b), 32'(s[1]));
        chk("b_valid", 32'(valid_b), 32'(v[1]));
        chk("b_overrun", 32'(ovr_b), 32'(ov[1]));
        chk("b_busy", 32'(busy_b), 32'(on[1]));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rate"}, 32'({rate_a, rate_b}), 32'h0);
        chk({tag, "_sat"}, 32'({sat_a, sat_b}), 32'h0);
        chk({tag, "_flags"}, 32'({valid_a, valid_b, ovr_a, ovr_b, busy_a, busy_b}), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        tick(1, 4'hF, 1);
        tick(1, 4'hF, 1);
        chk_zero("reset0");
        rst_n = 1'b1;

        // decoding: ch0 always, ch1 every other cycle, ch2 never, ch3 once
        tick(1, 4'h0, 1);
        for (int i = 0; i < 16; i++)
            tick(1, {(i == 0), 1'b0, (i % 2 == 0), 1'b1}, 1);
        chk("dec_rate", 32'(rate_a), 32'h108F);
        chk("dec_sat", 32'(sat_a), 32'h1);
        chk("dec_valid", 32'(valid_a), 32'h1);
        tick(1, 4'h0, 1);
        chk("dec_valid_drop", 32'(valid_a), 32'h0);

        // abort after 7 samples
        for (int i = 0; i < 6; i++) tick(1, 4'h0, 1);
        tick(0, 4'h0, 1);
        chk("abort_busy", 32'(busy_a), 32'h0);
        chk("abort_valid", 32'(valid_a), 32'h0);
        chk("abort_overrun", 32'(ovr_a), 32'h0);

        // fresh window, result held under backpressure
        tick(1, 4'h0, 0);
        for (int i = 0; i < 15; i++) tick(1, 4'h2, 0);
        chk("fresh_not_early", 32'(valid_a), 32'h0);
        tick(1, 4'h2, 0);
        chk("fresh_rate", 32'(rate_a), 32'h00F0);
        chk("fresh_sat", 32'(sat_a), 32'h2);
        for (int i = 0; i < 16; i++) tick(1, 4'h4, 0);
        chk("bp_overrun", 32'(ovr_a), 32'h1);
        chk("bp_rate_held", 32'(rate_a), 32'h00F0);
        chk("bp_valid_held", 32'(valid_a), 32'h1);
        tick(0, 4'h0, 0);
        chk("en_drop_keeps_valid", 32'(valid_a), 32'h1);
        tick(0, 4'h0, 1);
        chk("bp_xfer_valid", 32'(valid_a), 32'h0);
        chk("bp_xfer_rate", 32'(rate_a), 32'h00F0);

        // transfer coinciding with window completion
        tick(1, 4'h0, 0);
        for (int i = 0; i < 16; i++) tick(1, 4'h8, 0);
        chk("coin_first", 32'(rate_a), 32'hF000);
        for (int i = 0; i < 15; i++) tick(1, 4'h1, 0);
        tick(1, 4'h1, 1);
        chk("coin_valid", 32'(valid_a), 32'h1);
        chk("coin_rate", 32'(rate_a), 32'h000F);
        chk("coin_sat", 32'(sat_a), 32'h1);
        chk("coin_overrun_sticky", 32'(ovr_a), 32'h1);
        tick(1, 4'h0, 1);
        chk("coin_drain", 32'(valid_a), 32'h0);

        // minimum window on dut_b
        tick(0, 4'h0, 1);
        tick(0, 4'h0, 1);
        tick(1, 4'h0, 1);
        for (int k = 1; k <= 8; k++) begin
            tick(1, 4'hF, 1);
            chk("min_valid", 32'(valid_b), 32'(k % 2 == 0));
            if (k % 2 == 0) chk("min_rate", 32'(rate_b), 32'h2222);
        end

        // reset mid-window with a pending result
        tick(0, 4'h0, 1);
        tick(1, 4'h0, 0);
        for (int i = 0; i < 20; i++) tick(1, 4'h5, 0);
        chk("pre_reset_valid", 32'(valid_a), 32'h1);
        rst_n = 1'b0;
        tick(1, 4'hF, 0);
        tick(1, 4'hF, 0);
        chk_zero("reset1");
        rst_n = 1'b1;
        tick(0, 4'h0, 1);
        tick(0, 4'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
